mem_boot_arbiter: RTL and testbench
===================================

Name: mem_boot_arbiter

Overview:
- Owns the single port of the 64x8 program/data memory and shares it between the CPU and a program loader.
- Holds the CPU in reset while the loader writes the image (e.g. INC/ADD/AND/JMP program at 0-12, operands at 32-42), then releases the CPU.
- In run mode, the CPU and loader share the port by round-robin.
- Sits between the CPU's memory interface and the memory instance, in place of hierarchical preloading.

Parameters:
- AW, 6, memory address width (64 words)
- DW, 8, memory data width ({opcode[1:0], addr[5:0]} instruction words)

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  reset, synchronous, active-low
- ld_req  in  1  loader access request
- ld_we  in  1  loader write enable (0 = read)
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_rvalid  out  1  rdata valid for the loader's read
- ld_done  in  1  one-cycle pulse: image loaded, start CPU
- ld_halt  in  1  one-cycle pulse: stop CPU, return to boot
- cpu_resetn  out  1  active-low reset to CPU core
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  rdata valid for the CPU's read
- rdata  out  DW  read data (mem_rdata passthrough)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, 1-cycle synchronous latency

Behaviour:
- FSM states: BOOT, RUN. Reset state is BOOT.
- Reset values: state=BOOT, cpu_resetn=0, last-grant pointer=LD, ld_rvalid=0, cpu_rvalid=0.
- While resetn=0 in a cycle, ld_gnt, cpu_gnt, mem_en and mem_we are forced 0.

BOOT state:
- ld_gnt = ld_req. cpu_gnt = 0; cpu_req is ignored.
- cpu_resetn register = 0.
- ld_done=1 -> RUN at the next edge. A loader access in the same cycle is still served.
- ld_halt is ignored in BOOT.

RUN state:
- Only cpu_req -> CPU is granted.
- Only ld_req -> loader is granted.
- Both requesting -> grant the requester that is not the last-grant pointer.
- The pointer updates to the granted requester on every grant, in both states.
- First contention after entering RUN from reset -> CPU wins.
- ld_halt=1 -> BOOT at the next edge. ld_done is ignored in RUN.

cpu_resetn timing:
- Registered.
- Becomes 1 on the edge that enters RUN, so the CPU's first request is seen no earlier than the first RUN cycle.
- Becomes 0 on the edge that enters BOOT.

Grant and memory command:
- gnt is combinational from state and req; at most one gnt per cycle.
- A requester holds req, we, addr and wdata stable until gnt.
- The granted requester's we/addr/wdata drive mem_*, with mem_en=1, in the grant cycle. No grant -> mem_en=0, mem_we=0.
- mem_addr and mem_wdata hold their last value when idle.

Read return:
- A granted read (we=0) asserts the matching *_rvalid exactly 1 cycle later, for 1 cycle. rdata = mem_rdata.
- Writes never raise rvalid.

Mode-switch and reset corner cases:
- A CPU read granted in the last RUN cycle still gets cpu_rvalid in the first BOOT cycle.
- A synchronous reset in the cycle after a grant clears the pending rvalid.

Back-to-back and access rules:
- Back-to-back grants are allowed every cycle; full throughput is 1 access per cycle.
- No address checking; all AW bits pass through unchanged.

Test Plan:
- Boot load: hold resetn=0 for 2 cycles, release; loader writes mem[0]=0xE0, mem[1]=0x21, mem[32]=0x05 with cpu_req=1 throughout -> cpu_gnt=0 every cycle, cpu_resetn=0, three mem writes in consecutive cycles.
- Release: ld_done pulse -> cpu_resetn=1 on the next edge; CPU read of addr 0 -> cpu_gnt same cycle, cpu_rvalid next cycle with rdata=0xE0.
- Contention: in RUN, cpu_req and ld_req both held for 4 cycles -> grants alternate CPU, LD, CPU, LD.
- Sole requester: the loader alone for 3 cycles -> 3 consecutive ld_gnt with no gaps.
- Halt: CPU read of addr 32 granted in the same cycle as ld_halt -> BOOT and cpu_resetn=0 next edge; cpu_rvalid=1 with rdata=0x05 in that cycle; a CPU req in BOOT is never granted.
- Reset mid-run: resetn=0 for 1 cycle right after a granted CPU read -> cpu_rvalid stays 0, state=BOOT, cpu_resetn=0; a following contention in RUN grants the CPU first.

Source files
------------

// File: rtl/mem_boot_arbiter_if.sv
// Bundles the loader, CPU and memory-port signals seen by mem_boot_arbiter.
// The arbiter uses the slave modport; the loader/CPU/memory side uses master.
interface mem_boot_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic          ld_done;
  logic          ld_halt;

  logic          cpu_resetn;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_done, ld_halt,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output ld_gnt, ld_rvalid,
    output cpu_resetn, cpu_gnt, cpu_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata, ld_done, ld_halt,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  ld_gnt, ld_rvalid,
    input  cpu_resetn, cpu_gnt, cpu_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_boot_arbiter.sv
// Single-port memory arbiter: the loader owns the port in BOOT while the CPU is
// held in reset; in RUN the CPU and loader share the port round-robin.
//
// state | meaning
// BOOT  | loader-only access, cpu_resetn held low
// RUN   | CPU released, round-robin between CPU and loader
module mem_boot_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input logic              clk,
  input logic              resetn,
  mem_boot_arbiter_if.slave bus
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          last_cpu_q, last_cpu_d;
  logic          cpu_resetn_q, cpu_resetn_d;
  logic          ld_rvalid_q, ld_rvalid_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          ld_gnt;
  logic          cpu_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  always_comb begin
    state_d = state_q;
    ld_gnt  = 1'b0;
    cpu_gnt = 1'b0;

    unique case (state_q)
      BOOT: begin
        ld_gnt = bus.ld_req;
        if (bus.ld_done) state_d = RUN;
      end
      RUN: begin
        if (bus.cpu_req && bus.ld_req) begin
          // Contention: the side that did not win last time gets the port.
          cpu_gnt = ~last_cpu_q;
          ld_gnt  = last_cpu_q;
        end else begin
          cpu_gnt = bus.cpu_req;
          ld_gnt  = bus.ld_req;
        end
        if (bus.ld_halt) state_d = BOOT;
      end
      default: state_d = BOOT;
    endcase

    if (!resetn) begin
      ld_gnt  = 1'b0;
      cpu_gnt = 1'b0;
    end
  end

  always_comb begin
    mem_en    = ld_gnt | cpu_gnt;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (cpu_gnt) begin
      mem_we    = bus.cpu_we;
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
    end else if (ld_gnt) begin
      mem_we    = bus.ld_we;
      mem_addr  = bus.ld_addr;
      mem_wdata = bus.ld_wdata;
    end
  end

  always_comb begin
    last_cpu_d   = last_cpu_q;
    if (cpu_gnt)     last_cpu_d = 1'b1;
    else if (ld_gnt) last_cpu_d = 1'b0;
    cpu_resetn_d = (state_d == RUN);
    ld_rvalid_d  = ld_gnt & ~bus.ld_we;
    cpu_rvalid_d = cpu_gnt & ~bus.cpu_we;
    addr_d       = mem_addr;
    wdata_d      = mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= BOOT;
      last_cpu_q   <= 1'b0;
      cpu_resetn_q <= 1'b0;
      ld_rvalid_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_cpu_q   <= last_cpu_d;
      cpu_resetn_q <= cpu_resetn_d;
      ld_rvalid_q  <= ld_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // A read return pending across a reset cycle is suppressed immediately.
  assign bus.ld_rvalid  = ld_rvalid_q & resetn;
  assign bus.cpu_rvalid = cpu_rvalid_q & resetn;
  assign bus.cpu_resetn = cpu_resetn_q;
  assign bus.ld_gnt     = ld_gnt;
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.rdata      = bus.mem_rdata;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Directed bench for mem_boot_arbiter with a 64x8 synchronous-read memory model.
module tb_mem_boot_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  mem_boot_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_boot_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] mem_rd;
  assign bus.mem_rdata = mem_rd;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rd <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ld_req = req; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem_rd = '0;
    resetn = 1'b0;
    bus.ld_done = 1'b0;
    bus.ld_halt = 1'b0;
    set_ld(1'b1, 1'b1, 6'd0, 8'hE0);
    set_cpu(1'b1, 1'b0, 6'd0, 8'h00);
    #1;
    chk("rst_ld_gnt", bus.ld_gnt, 0);
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    cyc(); cyc();
    chk("rst_cpu_resetn", bus.cpu_resetn, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_ld_rvalid", bus.ld_rvalid, 0);

    // Boot load with cpu_req held high throughout
    resetn = 1'b1;
    #1;
    chk("boot0_ld_gnt", bus.ld_gnt, 1);
    chk("boot0_cpu_gnt", bus.cpu_gnt, 0);
    chk("boot0_mem_we", bus.mem_we, 1);
    chk("boot0_mem_addr", bus.mem_addr, 0);
    chk("boot0_mem_wdata", bus.mem_wdata, 8'hE0);
    cyc();
    set_ld(1'b1, 1'b1, 6'd1, 8'h21);
    #1;
    chk("boot1_ld_gnt", bus.ld_gnt, 1);
    chk("boot1_cpu_gnt", bus.cpu_gnt, 0);
    chk("boot1_mem_addr", bus.mem_addr, 1);
    chk("boot1_mem_wdata", bus.mem_wdata, 8'h21);
    cyc();
    set_ld(1'b1, 1'b1, 6'd32, 8'h05);
    bus.ld_done = 1'b1;
    #1;
    chk("boot2_ld_gnt", bus.ld_gnt, 1);
    chk("boot2_cpu_gnt", bus.cpu_gnt, 0);
    chk("boot2_mem_addr", bus.mem_addr, 32);
    chk("boot2_cpu_resetn", bus.cpu_resetn, 0);

    // First RUN cycle: CPU reads address 0
    cyc();
    bus.ld_done = 1'b0;
    set_ld(1'b0, 1'b0, 6'd0, 8'h00);
    #1;
    chk("run_cpu_resetn", bus.cpu_resetn, 1);
    chk("run_ld_rvalid_after_write", bus.ld_rvalid, 0);
    chk("run_cpu_gnt", bus.cpu_gnt, 1);
    chk("run_mem_we", bus.mem_we, 0);
    chk("run_mem_addr", bus.mem_addr, 0);

    // Loader alone for 3 cycles: reads 1, 32, 0
    cyc();
    set_cpu(1'b0, 1'b0, 6'd0, 8'h00);
    set_ld(1'b1, 1'b0, 6'd1, 8'h00);
    #1;
    chk("cpu_rvalid0", bus.cpu_rvalid, 1);
    chk("cpu_rdata0", bus.rdata, 8'hE0);
    chk("solo0_ld_gnt", bus.ld_gnt, 1);
    chk("solo0_mem_addr", bus.mem_addr, 1);
    cyc();
    set_ld(1'b1, 1'b0, 6'd32, 8'h00);
    #1;
    chk("solo0_ld_rvalid", bus.ld_rvalid, 1);
    chk("solo0_rdata", bus.rdata, 8'h21);
    chk("solo0_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("solo1_ld_gnt", bus.ld_gnt, 1);
    cyc();
    set_ld(1'b1, 1'b0, 6'd0, 8'h00);
    #1;
    chk("solo1_rdata", bus.rdata, 8'h05);
    chk("solo2_ld_gnt", bus.ld_gnt, 1);
    cyc();
    // Contention for 4 cycles: CPU reads 1, loader writes 40
    set_cpu(1'b1, 1'b0, 6'd1, 8'h00);
    set_ld(1'b1, 1'b1, 6'd40, 8'hAA);
    #1;
    chk("solo2_ld_rvalid", bus.ld_rvalid, 1);
    chk("solo2_rdata", bus.rdata, 8'hE0);
    chk("cont0_cpu_gnt", bus.cpu_gnt, 1);
    chk("cont0_ld_gnt", bus.ld_gnt, 0);
    cyc();
    chk("cont0_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("cont0_rdata", bus.rdata, 8'h21);
    chk("cont1_cpu_gnt", bus.cpu_gnt, 0);
    chk("cont1_ld_gnt", bus.ld_gnt, 1);
    chk("cont1_mem_we", bus.mem_we, 1);
    chk("cont1_mem_addr", bus.mem_addr, 40);
    cyc();
    chk("cont1_ld_rvalid", bus.ld_rvalid, 0);
    chk("cont2_cpu_gnt", bus.cpu_gnt, 1);
    chk("cont2_ld_gnt", bus.ld_gnt, 0);
    cyc();
    chk("cont3_cpu_gnt", bus.cpu_gnt, 0);
    chk("cont3_ld_gnt", bus.ld_gnt, 1);

    // Halt in the same cycle as a CPU read of 32
    cyc();
    set_ld(1'b0, 1'b0, 6'd0, 8'h00);
    set_cpu(1'b1, 1'b0, 6'd32, 8'h00);
    bus.ld_halt = 1'b1;
    #1;
    chk("halt_cpu_gnt", bus.cpu_gnt, 1);
    cyc();
    bus.ld_halt = 1'b0;
    #1;
    chk("halt_cpu_resetn", bus.cpu_resetn, 0);
    chk("halt_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("halt_rdata", bus.rdata, 8'h05);
    chk("boot_cpu_gnt_a", bus.cpu_gnt, 0);
    chk("boot_mem_en_a", bus.mem_en, 0);
    cyc();
    chk("boot_cpu_gnt_b", bus.cpu_gnt, 0);
    chk("boot_cpu_rvalid_b", bus.cpu_rvalid, 0);

    // Back to RUN, then reset right after a granted CPU read
    bus.ld_done = 1'b1;
    #1;
    chk("boot_cpu_gnt_c", bus.cpu_gnt, 0);
    cyc();
    bus.ld_done = 1'b0;
    #1;
    chk("run2_cpu_resetn", bus.cpu_resetn, 1);
    chk("run2_cpu_gnt", bus.cpu_gnt, 1);
    cyc();
    resetn = 1'b0;
    #1;
    chk("rst2_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst2_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst2_mem_en", bus.mem_en, 0);
    cyc();
    resetn = 1'b1;
    #1;
    chk("rst2_cpu_rvalid_after", bus.cpu_rvalid, 0);
    chk("rst2_cpu_resetn", bus.cpu_resetn, 0);
    chk("rst2_boot_cpu_gnt", bus.cpu_gnt, 0);
    bus.ld_done = 1'b1;
    cyc();
    bus.ld_done = 1'b0;
    set_cpu(1'b1, 1'b0, 6'd0, 8'h00);
    set_ld(1'b1, 1'b0, 6'd1, 8'h00);
    #1;
    chk("rst2_cont0_cpu_gnt", bus.cpu_gnt, 1);
    chk("rst2_cont0_ld_gnt", bus.ld_gnt, 0);
    cyc();
    chk("rst2_cont0_rdata", bus.rdata, 8'hE0);
    chk("rst2_cont1_ld_gnt", bus.ld_gnt, 1);
    chk("rst2_cont1_cpu_gnt", bus.cpu_gnt, 0);
    cyc();
    set_cpu(1'b0, 1'b0, 6'd0, 8'h00);
    set_ld(1'b0, 1'b0, 6'd0, 8'h00);
    #1;
    chk("rst2_cont1_ld_rvalid", bus.ld_rvalid, 1);
    chk("rst2_cont1_rdata", bus.rdata, 8'h21);
    chk("idle_mem_en", bus.mem_en, 0);
    chk("idle_mem_addr_hold", bus.mem_addr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
